// File: rtl/l4_buffer_reader_pkg.sv
// l4_buffer_reader_pkg
//   Shared declarations for the L4 buffer read side: per-buffer status codes
//   (same encoding the status registers use) and the reader FSM encoding.
package l4_buffer_reader_pkg;

  // Buffer status codes. Only ST_FULL makes a buffer eligible for service;
  // every other code, including unrecognised ones, is skipped by the reader.
  localparam int unsigned STATUS_W = 4;
  localparam logic [STATUS_W-1:0] ST_EMPTY = 4'b0000;
  localparam logic [STATUS_W-1:0] ST_FULL  = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

endpackage

// File: rtl/l4_rr_arbiter.sv
// l4_rr_arbiter
//   Combinational rotate-priority selector. The search starts at the buffer
//   just after rr_ptr_i and wraps, so rr_ptr_i itself has lowest priority.
// Ports:
//   req_i          request vector, one bit per buffer
//   rr_ptr_i       index of the most recently served buffer
//   grant_valid_o  at least one request is set
//   grant_idx_o    index of the winning request (0 when none)
module l4_rr_arbiter #(
  parameter int NBUF     = 4,
  parameter int LOG_NBUF = 2
) (
  input  logic [NBUF-1:0]     req_i,
  input  logic [LOG_NBUF-1:0] rr_ptr_i,
  output logic                grant_valid_o,
  output logic [LOG_NBUF-1:0] grant_idx_o
);

  logic [LOG_NBUF-1:0] cand;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand          = '0;
    for (int k = 1; k <= NBUF; k++) begin
      cand = LOG_NBUF'((int'(rr_ptr_i) + k) % NBUF);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/l4_buffer_reader.sv
// l4_buffer_reader
//   Scans the per-buffer status codes round-robin, streams the chosen
//   buffer's fixed-length packet from synchronous RAM onto a valid/ready
//   link, then pulses that buffer's set_empty to hand it back to writers.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a FULL buffer; grants on the closing edge
//   S_FETCH | RAM address presented, read data not yet available
//   S_SEND  | RAM data on tx_data with tx_valid; held until tx_ready
//   S_CLEAR | one-cycle set_empty pulse for the served buffer
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   status        packed status codes, buffer i at [i*NBITS +: NBITS]
//   set_empty     one-hot single-cycle clear to the served status register
//   mem_raddr     RAM read address {buffer index, word count}
//   mem_rdata     RAM read data, one cycle after mem_raddr
//   tx_data/tx_valid/tx_ready/tx_last  output link
//   busy          high whenever the FSM is not idle
module l4_buffer_reader
  import l4_buffer_reader_pkg::*;
#(
  parameter int NBITS     = 4,
  parameter int NBUF      = 4,
  parameter int LOG_NBUF  = 2,
  parameter int PKT_WORDS = 8,
  parameter int LOG_PKT   = 3,
  parameter int DW        = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NBUF*NBITS-1:0]       status,
  output logic [NBUF-1:0]             set_empty,
  output logic [LOG_NBUF+LOG_PKT-1:0] mem_raddr,
  input  logic [DW-1:0]               mem_rdata,
  output logic [DW-1:0]               tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_last,
  output logic                        busy
);

  state_e              state_q, state_d;
  logic [LOG_NBUF-1:0] rr_ptr_q, rr_ptr_d;
  logic [LOG_NBUF-1:0] cur_idx_q, cur_idx_d;
  logic [LOG_PKT-1:0]  word_cnt_q, word_cnt_d;

  logic [NBUF-1:0]     req;
  logic                grant_valid;
  logic [LOG_NBUF-1:0] grant_idx;
  logic                last_word;

  always_comb begin
    req = '0;
    for (int i = 0; i < NBUF; i++) begin
      req[i] = (status[i*NBITS +: NBITS] == NBITS'(ST_FULL));
    end
  end

  l4_rr_arbiter #(
    .NBUF     (NBUF),
    .LOG_NBUF (LOG_NBUF)
  ) u_arb (
    .req_i         (req),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  assign last_word = (word_cnt_q == LOG_PKT'(PKT_WORDS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= LOG_NBUF'(NBUF - 1);
      cur_idx_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_idx_q  <= cur_idx_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Status is only consulted in S_IDLE; changes during a packet are ignored.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_idx_d  = cur_idx_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          cur_idx_d  = grant_idx;
          word_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (tx_ready) begin
          if (last_word) begin
            state_d = S_CLEAR;
          end else begin
            word_cnt_d = word_cnt_q + LOG_PKT'(1);
            state_d    = S_FETCH;
          end
        end
      end
      S_CLEAR: begin
        rr_ptr_d   = cur_idx_q;
        word_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from registered state so an asynchronous reset
  // drops them in the same cycle.
  always_comb begin
    set_empty = '0;
    if (state_q == S_CLEAR) begin
      set_empty[cur_idx_q] = 1'b1;
    end
  end

  assign mem_raddr = {cur_idx_q, word_cnt_q};
  assign tx_data   = mem_rdata;
  assign tx_valid  = (state_q == S_SEND);
  assign tx_last   = (state_q == S_SEND) && last_word;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_l4_buffer_reader.sv
module tb_l4_buffer_reader;
  import l4_buffer_reader_pkg::*;

  localparam int NBITS = 4;
  localparam int NBUF  = 4;
  localparam int LNB   = 2;
  localparam int PKT   = 8;
  localparam int LPKT  = 3;
  localparam int DW    = 32;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b1;
  logic [NBUF*NBITS-1:0]  status_bus;
  logic [NBUF-1:0]        set_empty;
  logic [LNB+LPKT-1:0]    mem_raddr;
  logic [DW-1:0]          mem_rdata;
  logic [DW-1:0]          tx_data;
  logic                   tx_valid;
  logic                   tx_ready = 1'b0;
  logic                   tx_last;
  logic                   busy;

  logic [NBITS-1:0]       status_r [NBUF];
  logic [DW-1:0]          ram [NBUF*PKT];

  int n_vec = 0;
  int n_err = 0;

  // reference model state: transaction-level view of the reader
  int m_ptr = NBUF - 1;
  bit m_active = 0, m_gap = 0, m_clear = 0;
  int m_buf = 0, m_word = 0;

  always #5 clk = ~clk;

  always_comb begin
    status_bus = '0;
    for (int i = 0; i < NBUF; i++) status_bus[i*NBITS +: NBITS] = status_r[i];
  end

  always @(posedge clk) mem_rdata <= ram[mem_raddr];

  l4_buffer_reader dut (
    .clk       (clk),
    .resetn    (resetn),
    .status    (status_bus),
    .set_empty (set_empty),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    for (int k = 1; k <= NBUF; k++) begin
      int idx;
      idx = (m_ptr + k) % NBUF;
      if (status_r[idx] == ST_FULL) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: called at a falling edge with inputs already set.
  task automatic step();
    logic [NBUF-1:0] e_se;
    bit              e_valid;
    int              w;
    #1;
    if (!resetn) begin
      chk("rst_valid", 64'(tx_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_set_empty", 64'(set_empty), 0);
      chk("rst_last", 64'(tx_last), 0);
      chk("rst_raddr", 64'(mem_raddr), 0);
      m_active = 0; m_gap = 0; m_clear = 0; m_ptr = NBUF - 1;
    end else begin
      e_valid = m_active && !m_gap && !m_clear;
      e_se    = (m_active && m_clear) ? (NBUF'(1) << m_buf) : '0;
      chk("busy", 64'(busy), 64'(m_active));
      chk("tx_valid", 64'(tx_valid), 64'(e_valid));
      chk("set_empty", 64'(set_empty), 64'(e_se));
      if (e_valid) begin
        chk("tx_data", 64'(tx_data), 64'(ram[m_buf*PKT + m_word]));
        chk("tx_last", 64'(tx_last), 64'(m_word == PKT - 1));
        chk("raddr_send", 64'(mem_raddr), 64'(m_buf*PKT + m_word));
      end else if (m_active && m_gap) begin
        chk("raddr_fetch", 64'(mem_raddr), 64'(m_buf*PKT + m_word));
      end
      for (int i = 0; i < NBUF; i++) if (set_empty[i]) status_r[i] = ST_EMPTY;
      if (!m_active) begin
        w = pick_winner();
        if (w >= 0) begin
          m_active = 1; m_buf = w; m_word = 0; m_gap = 1;
        end
      end else if (m_clear) begin
        m_ptr = m_buf; m_active = 0; m_clear = 0;
      end else if (m_gap) begin
        m_gap = 0;
      end else if (tx_ready) begin
        if (m_word == PKT - 1) m_clear = 1;
        else begin
          m_word++;
          m_gap = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NBUF; i++) status_r[i] = ST_EMPTY;
    resetn = 1'b0;
    run(2);
    resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NBUF; i++) status_r[i] = ST_EMPTY;
    for (int i = 0; i < NBUF*PKT; i++) ram[i] = $urandom;
    #2 resetn = 1'b0;
    @(negedge clk);

    // single buffer, known data
    do_reset();
    for (int k = 0; k < PKT; k++) ram[2*PKT + k] = 32'h2000_0000 + k;
    tx_ready = 1'b1;
    status_r[2] = ST_FULL;
    run(24);

    // three buffers full from reset: order 0,1,3
    do_reset();
    status_r[0] = ST_FULL; status_r[1] = ST_FULL; status_r[3] = ST_FULL;
    run(3*(2*PKT + 2) + 6);

    // backpressure on word 3
    do_reset();
    status_r[1] = ST_FULL;
    run(8);
    tx_ready = 1'b0;
    run(5);
    tx_ready = 1'b1;
    run(16);

    // unrecognised status code on buffer 0
    do_reset();
    status_r[0] = 4'b1010;
    status_r[1] = ST_FULL;
    run(26);

    // reset mid-packet at word 4, then restart
    do_reset();
    status_r[3] = ST_FULL;
    run(10);
    resetn = 1'b0;
    run(2);
    resetn = 1'b1;
    run(24);

    // status dropped externally during word 2
    do_reset();
    status_r[0] = ST_FULL;
    run(6);
    status_r[0] = ST_EMPTY;
    run(20);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tx_ready = ($urandom_range(9) < 7);
      if ($urandom_range(7) == 0) begin
        int b, r;
        b = $urandom_range(NBUF - 1);
        if (!(m_active && b == m_buf)) begin
          r = $urandom_range(9);
          if (r < 6) begin
            for (int k = 0; k < PKT; k++) ram[b*PKT + k] = $urandom;
            status_r[b] = ST_FULL;
          end else if (r < 8) begin
            status_r[b] = ST_EMPTY;
          end else begin
            status_r[b] = (r == 8) ? 4'b1010 : 4'b0101;
          end
        end
      end
      if ($urandom_range(499) == 0) begin
        resetn = 1'b0;
        run(2);
        resetn = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
